// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings, address map constants and FSM state type for the
// pipeline hazard/stall controller.
package pipeline_ctrl_pkg;

  localparam logic [1:0]  MEM_LOAD     = 2'b00;
  localparam logic [1:0]  MEM_STORE    = 2'b01;
  localparam logic [1:0]  MEM_NONE     = 2'b11;
  localparam logic [3:0]  REG_NONE     = 4'hF;
  localparam logic [15:0] IMEM_LIMIT   = 16'h8000;
  localparam logic [15:0] PERIPH_BASE  = 16'hBF00;
  localparam logic [7:0]  WAIT_TIMEOUT = 8'd255;

  typedef enum logic {
    ST_RUN,
    ST_MEM_WAIT
  } state_t;

  typedef struct packed {
    logic ram_owner;
    logic pc_keep;
    logic if_keep;
    logic if_clear;
    logic id_keep;
    logic id_clear;
    logic ex_keep;
    logic wb_clear;
  } ctrl_t;

  // Encoding 2'b10 is deliberately treated as "no access".
  function automatic logic is_mem_access(input logic [1:0] op);
    return (op == MEM_LOAD) || (op == MEM_STORE);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detection: the ID instruction reads a register that the
// load currently in EXE has not yet produced.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [3:0] id_rreg1,
  input  logic [3:0] id_rreg2,
  input  logic       id_use1,
  input  logic       id_use2,
  input  logic [3:0] ex_wreg,
  input  logic [1:0] ex_controlmem,
  output logic       load_use
);

  logic src1_hit;
  logic src2_hit;

  assign src1_hit = id_use1 && (id_rreg1 == ex_wreg);
  assign src2_hit = id_use2 && (id_rreg2 == ex_wreg);
  assign load_use = (ex_controlmem == MEM_LOAD) && (ex_wreg != REG_NONE)
                    && (src1_hit || src2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: branch flush, load-use stall, instruction-RAM
// arbitration and peripheral wait freeze with timeout.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  id_rreg1,
  input  logic [3:0]  id_rreg2,
  input  logic        id_use1,
  input  logic        id_use2,
  input  logic [3:0]  ex_wreg,
  input  logic [1:0]  ex_controlmem,
  input  logic        ex_jump,
  input  logic [1:0]  mem_controlmem,
  input  logic [15:0] mem_addr,
  input  logic        mem_ready,
  output logic        pcKeep,
  output logic        ifKeep,
  output logic        ifClear,
  output logic        idKeep,
  output logic        idClear,
  output logic        exKeep,
  output logic        wbClear,
  output logic        ram_owner,
  output logic [15:0] stall_cnt,
  output logic        timeout_err
);

  state_t     state, state_next;
  logic [7:0] wait_cnt, wait_cnt_next;
  logic       timeout_set;
  logic       run_rules;
  logic       load_use;
  logic       mem_access;
  logic       periph_busy;
  logic       struct_hz;
  ctrl_t      ctrl;

  hazard_detect u_hazard_detect (
    .id_rreg1      (id_rreg1),
    .id_rreg2      (id_rreg2),
    .id_use1       (id_use1),
    .id_use2       (id_use2),
    .ex_wreg       (ex_wreg),
    .ex_controlmem (ex_controlmem),
    .load_use      (load_use)
  );

  assign mem_access  = is_mem_access(mem_controlmem);
  assign periph_busy = mem_access && (mem_addr >= PERIPH_BASE) && !mem_ready;
  assign struct_hz   = mem_access && (mem_addr < IMEM_LIMIT);

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    ctrl          = '0;
    state_next    = state;
    wait_cnt_next = wait_cnt;
    timeout_set   = 1'b0;
    run_rules     = 1'b0;

    case (state)
      ST_RUN: begin
        if (periph_busy) begin
          ctrl          = '{pc_keep: 1'b1, if_keep: 1'b1, id_keep: 1'b1,
                            ex_keep: 1'b1, wb_clear: 1'b1, default: 1'b0};
          state_next    = ST_MEM_WAIT;
          wait_cnt_next = '0;
        end else begin
          run_rules = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          run_rules  = 1'b1;
          state_next = ST_RUN;
        end else if (wait_cnt == WAIT_TIMEOUT) begin
          run_rules   = 1'b1;
          timeout_set = 1'b1;
          state_next  = ST_RUN;
        end else begin
          ctrl          = '{pc_keep: 1'b1, if_keep: 1'b1, id_keep: 1'b1,
                            ex_keep: 1'b1, wb_clear: 1'b1, default: 1'b0};
          wait_cnt_next = wait_cnt + 8'd1;
        end
      end
      default: state_next = ST_RUN;
    endcase

    // Branch beats load-use; a structural conflict only adds the RAM grant
    // when either of those already controls the front end.
    if (run_rules) begin
      ctrl.ram_owner = struct_hz;
      if (ex_jump) begin
        ctrl.if_clear = 1'b1;
        ctrl.id_clear = 1'b1;
      end else if (load_use) begin
        ctrl.pc_keep  = 1'b1;
        ctrl.if_keep  = 1'b1;
        ctrl.id_clear = 1'b1;
      end else if (struct_hz) begin
        ctrl.pc_keep  = 1'b1;
        ctrl.if_clear = 1'b1;
      end
    end

    if (rst) ctrl = '0;
  end

  assign ram_owner = ctrl.ram_owner;
  assign pcKeep    = ctrl.pc_keep;
  assign ifKeep    = ctrl.if_keep;
  assign ifClear   = ctrl.if_clear;
  assign idKeep    = ctrl.id_keep;
  assign idClear   = ctrl.id_clear;
  assign exKeep    = ctrl.ex_keep;
  assign wbClear   = ctrl.wb_clear;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      wait_cnt    <= '0;
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (ctrl.pc_keep && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      if (timeout_set) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  id_rreg1, id_rreg2;
  logic        id_use1, id_use2;
  logic [3:0]  ex_wreg;
  logic [1:0]  ex_controlmem;
  logic        ex_jump;
  logic [1:0]  mem_controlmem;
  logic [15:0] mem_addr;
  logic        mem_ready;
  logic        pcKeep, ifKeep, ifClear, idKeep, idClear, exKeep, wbClear;
  logic        ram_owner;
  logic [15:0] stall_cnt;
  logic        timeout_err;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 0;

  // Model state: are we waiting on a peripheral, for how long, and counters.
  bit m_waiting;
  int m_wait;
  int m_stall;
  bit m_tout;

  // Output vector order: {ram_owner,pcKeep,ifKeep,ifClear,idKeep,idClear,exKeep,wbClear}
  localparam logic [7:0] V_FREEZE = 8'h6B;
  localparam logic [7:0] V_LU     = 8'h64;
  localparam logic [7:0] V_BRANCH = 8'h14;
  localparam logic [7:0] V_STRUCT = 8'hD0;

  pipeline_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rreg1(id_rreg1), .id_rreg2(id_rreg2),
    .id_use1(id_use1), .id_use2(id_use2),
    .ex_wreg(ex_wreg), .ex_controlmem(ex_controlmem), .ex_jump(ex_jump),
    .mem_controlmem(mem_controlmem), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .pcKeep(pcKeep), .ifKeep(ifKeep), .ifClear(ifClear), .idKeep(idKeep),
    .idClear(idClear), .exKeep(exKeep), .wbClear(wbClear),
    .ram_owner(ram_owner), .stall_cnt(stall_cnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] dut_vec();
    return {ram_owner, pcKeep, ifKeep, ifClear, idKeep, idClear, exKeep, wbClear};
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model of the control outputs for the current cycle.
  function automatic logic [7:0] model_out();
    bit accesses, periph_stall, imem_conflict, hazard, frozen;
    bit [3:0] srcs [2];
    bit uses [2];
    bit ram, pc, ifk, ifc, idc;
    if (rst) return 8'h00;
    accesses      = (mem_controlmem == 2'b00) || (mem_controlmem == 2'b01);
    periph_stall  = accesses && (int'(mem_addr) >= 'hBF00) && !mem_ready;
    imem_conflict = accesses && (int'(mem_addr) < 'h8000);
    srcs[0] = id_rreg1; srcs[1] = id_rreg2;
    uses[0] = id_use1;  uses[1] = id_use2;
    hazard = 0;
    if (ex_controlmem == 2'b00 && ex_wreg != 4'hF)
      for (int k = 0; k < 2; k++)
        if (uses[k] && srcs[k] == ex_wreg) hazard = 1;
    frozen = m_waiting ? (!mem_ready && m_wait < 255) : periph_stall;
    if (frozen) return V_FREEZE;
    ram = imem_conflict;
    pc = 0; ifk = 0; ifc = 0; idc = 0;
    if (ex_jump) begin
      ifc = 1; idc = 1;
    end else if (hazard) begin
      pc = 1; ifk = 1; idc = 1;
    end else if (imem_conflict) begin
      pc = 1; ifc = 1;
    end
    return {ram, pc, ifk, ifc, 1'b0, idc, 1'b0, 1'b0};
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_ctrl", int'(dut_vec()), int'(model_out()));
      check("model_stall_cnt", int'(stall_cnt), m_stall);
      check("model_timeout_err", int'(timeout_err), int'(m_tout));
    end
  end

  always @(posedge clk) begin
    logic [7:0] o;
    bit accesses;
    o = model_out();
    if (rst) begin
      m_waiting = 0; m_wait = 0; m_stall = 0; m_tout = 0;
    end else begin
      if (o[6] && m_stall < 65535) m_stall++;
      accesses = (mem_controlmem == 2'b00) || (mem_controlmem == 2'b01);
      if (!m_waiting) begin
        if (accesses && int'(mem_addr) >= 'hBF00 && !mem_ready) begin
          m_waiting = 1; m_wait = 0;
        end
      end else if (mem_ready) begin
        m_waiting = 0;
      end else if (m_wait == 255) begin
        m_waiting = 0; m_tout = 1;
      end else begin
        m_wait++;
      end
    end
  end

  task automatic idle();
    id_rreg1 = 4'd0; id_rreg2 = 4'd0; id_use1 = 0; id_use2 = 0;
    ex_wreg = 4'hF; ex_controlmem = 2'b11; ex_jump = 0;
    mem_controlmem = 2'b11; mem_addr = 16'h0000; mem_ready = 1;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  initial begin
    int freezes;
    int s0;
    rst = 1;
    idle();
    id_rreg1 = 4'd3; id_use1 = 1; ex_wreg = 4'd3; ex_controlmem = 2'b00;
    next_cycle();
    next_cycle();
    sample();
    check("rst_outputs_zero", int'(dut_vec()), 0);
    check("rst_stall_cnt", int'(stall_cnt), 0);
    check("rst_timeout_err", int'(timeout_err), 0);
    cmp_en = 1;
    next_cycle();
    rst = 0;
    idle();

    // Load-use stall for one cycle.
    next_cycle();
    sample();
    s0 = int'(stall_cnt);
    next_cycle();
    id_rreg1 = 4'd3; id_use1 = 1; ex_wreg = 4'd3; ex_controlmem = 2'b00;
    sample();
    check("load_use_ctrl", int'(dut_vec()), int'(V_LU));
    next_cycle();
    idle();
    sample();
    check("load_use_stall_inc", int'(stall_cnt), s0 + 1);

    // Branch overrides load-use.
    next_cycle();
    id_rreg1 = 4'd3; id_use1 = 1; ex_wreg = 4'd3; ex_controlmem = 2'b00; ex_jump = 1;
    sample();
    check("branch_ctrl", int'(dut_vec()), int'(V_BRANCH));

    // Structural conflict and the address boundary.
    next_cycle();
    idle();
    mem_controlmem = 2'b01; mem_addr = 16'h4000;
    sample();
    check("struct_ctrl", int'(dut_vec()), int'(V_STRUCT));
    next_cycle();
    mem_addr = 16'h8000;
    sample();
    check("struct_boundary", int'(dut_vec()), 0);

    // Peripheral wait: entry plus three low cycles, then ready.
    freezes = 0;
    next_cycle();
    idle();
    mem_controlmem = 2'b00; mem_addr = 16'hBF00; mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) next_cycle();
      sample();
      if (dut_vec() == V_FREEZE) freezes++;
    end
    check("periph_freeze_cycles", freezes, 4);
    next_cycle();
    mem_ready = 1;
    sample();
    check("periph_release", int'(dut_vec()), 0);
    next_cycle();
    idle();
    mem_ready = 0;
    sample();
    check("periph_back_in_run", int'(dut_vec()), 0);

    // Timeout: ready held low until the controller gives up.
    freezes = 0;
    next_cycle();
    mem_controlmem = 2'b00; mem_addr = 16'hBFF0; mem_ready = 0;
    for (int i = 0; i < 400; i++) begin
      if (i > 0) next_cycle();
      sample();
      if (!exKeep) break;
      freezes++;
    end
    check("timeout_freeze_cycles", freezes, 256);
    next_cycle();
    idle();
    sample();
    check("timeout_err_set", int'(timeout_err), 1);
    repeat (3) next_cycle();
    sample();
    check("timeout_err_sticky", int'(timeout_err), 1);

    // Reset mid-wait.
    next_cycle();
    mem_controlmem = 2'b01; mem_addr = 16'hC000; mem_ready = 0;
    next_cycle();
    next_cycle();
    rst = 1;
    sample();
    check("rst_mid_wait_outputs", int'(dut_vec()), 0);
    next_cycle();
    rst = 0;
    idle();
    mem_ready = 0;
    sample();
    check("rst_mid_wait_run", int'(dut_vec()), 0);
    check("rst_mid_wait_stall", int'(stall_cnt), 0);
    check("rst_mid_wait_timeout", int'(timeout_err), 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      rst            = ($urandom_range(0, 199) == 0);
      id_rreg1       = 4'($urandom_range(0, 3));
      id_rreg2       = 4'($urandom_range(0, 3));
      id_use1        = 1'($urandom);
      id_use2        = 1'($urandom);
      ex_wreg        = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
      ex_controlmem  = 2'($urandom);
      ex_jump        = ($urandom_range(0, 7) == 0);
      mem_controlmem = 2'($urandom);
      case ($urandom_range(0, 2))
        0:       mem_addr = 16'($urandom_range(0, 'h7FFF));
        1:       mem_addr = 16'($urandom_range('h8000, 'hBEFF));
        default: mem_addr = 16'($urandom_range('hBF00, 'hFFFF));
      endcase
      mem_ready      = ($urandom_range(0, 2) == 0);
    end
    next_cycle();
    rst = 0;
    idle();
    sample();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
